// File: rtl/frequency_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : frequency_counter                                             |
// | Purpose  : Counts rising edges of an asynchronous input over a gate      |
// |            window of BASE_TICKS << freq clock cycles and publishes the   |
// |            count with a one-cycle valid strobe at the end of each window.|
// | Ports    : CLK    - system clock, all state on rising edge               |
// |            RST_N  - async active-low reset, release synchronised (2-FF)  |
// |            IN     - signal under measurement, asynchronous to CLK        |
// |            freq   - gate-window select, sampled at each window start     |
// |            count  - rising edges of IN in the last completed window      |
// |            valid  - one-cycle pulse when count is updated                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module frequency_counter #(
  parameter int BASE_TICKS = 50000,  // cycles in the shortest window, >= 4
  parameter int COUNT_W    = 32,     // width of the edge count
  parameter int GATE_W     = 32      // must hold BASE_TICKS << 15
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               IN,
  input  logic [3:0]         freq,
  output logic [COUNT_W-1:0] count,
  output logic               valid
);

  localparam logic [GATE_W-1:0]  BASE_W   = GATE_W'(BASE_TICKS);
  localparam logic [GATE_W-1:0]  GATE_ONE = GATE_W'(1);
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);

  // ------------------------------------------------------------------------
  // Reset conditioning: assertion is immediate, release is delayed by two
  // clock edges so every downstream flop leaves reset on the same edge.
  // ------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync[1];

  // ------------------------------------------------------------------------
  // Input conditioning: 2-FF synchroniser followed by a previous-value
  // register. A rise is one cycle where the synchronised value is 1 and the
  // previous one was 0, so at most one edge is seen per clock.
  // ------------------------------------------------------------------------
  logic in_meta;
  logic in_sync;
  logic in_prev;
  logic rise;

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      in_meta <= 1'b0;
      in_sync <= 1'b0;
      in_prev <= 1'b0;
    end else begin
      in_meta <= IN;
      in_sync <= in_meta;
      in_prev <= in_sync;
    end
  end

  assign rise = in_sync & ~in_prev;

  // ------------------------------------------------------------------------
  // Gate window and accumulator.
  // freq is latched while the gate counter sits at 0, i.e. on the first
  // cycle of every window (including the first after reset). The terminal
  // compare during that cycle still uses the previous latched value, which
  // is harmless because a window is always at least 4 cycles long.
  // ------------------------------------------------------------------------
  logic [GATE_W-1:0]  gate_cnt;
  logic [3:0]         freq_lat;
  logic [COUNT_W-1:0] acc;
  logic [GATE_W-1:0]  window_last;
  logic               window_start;
  logic               window_end;
  logic [COUNT_W-1:0] acc_next;

  assign window_last  = (BASE_W << freq_lat) - GATE_ONE;
  assign window_start = (gate_cnt == '0);
  assign window_end   = (gate_cnt == window_last);

  // Saturating increment: the count sticks at all-ones rather than wrapping.
  assign acc_next = (rise && !(&acc)) ? acc + CNT_ONE : acc;

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      gate_cnt <= '0;
      freq_lat <= 4'd0;
      acc      <= '0;
      count    <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (window_start) begin
        freq_lat <= freq;
      end
      if (window_end) begin
        // The edge seen on the last cycle belongs to the closing window.
        count    <= acc_next;
        valid    <= 1'b1;
        acc      <= '0;
        gate_cnt <= '0;
      end else begin
        acc      <= acc_next;
        gate_cnt <= gate_cnt + GATE_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frequency_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_frequency_counter                                          |
// | Purpose  : Self-checking bench for frequency_counter. Two instances share |
// |            stimulus: a wide-count one and a 4-bit one that saturates.    |
// |            A history-based reference model predicts count/valid on every |
// |            cycle; a vector table and hand sequences add fixed checks.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_frequency_counter;

  localparam int BASE = 64;
  localparam int CW   = 16;
  localparam int SW   = 4;
  localparam int MAXC = 65536;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          in_sig = 1'b0;
  logic [3:0]    freq   = 4'd0;
  logic [CW-1:0] count;
  logic          valid;
  logic [SW-1:0] count_s;
  logic          valid_s;

  always #10 clk = ~clk;

  frequency_counter #(.BASE_TICKS(BASE), .COUNT_W(CW), .GATE_W(32)) dut (
    .CLK(clk), .RST_N(rst_n), .IN(in_sig), .freq(freq), .count(count), .valid(valid)
  );

  frequency_counter #(.BASE_TICKS(BASE), .COUNT_W(SW), .GATE_W(32)) dut_sat (
    .CLK(clk), .RST_N(rst_n), .IN(in_sig), .freq(freq), .count(count_s), .valid(valid_s)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: IN and freq as seen at each rising edge since
  // reset release (index 1 = first edge after release).
  bit         s_hist[MAXC];
  logic [3:0] f_hist[MAXC];
  int  cyc = 0;
  bit  in_reset = 1'b1;
  bit  release_pending = 1'b0;
  int  win_start = 3;
  int  win_end = -1;
  int  exp_main = 0;
  int  exp_sat = 0;

  // Stimulus mode
  bit  rand_mode = 1'b0;
  int  hold_half = 0;
  bit  hold_level = 1'b0;
  int  tog_cnt = 0;

  typedef struct {
    int         half;
    bit         level;
    logic [3:0] f;
    int         exp;
    int         exp_sat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit sv(input int k);
    return (k < 3) ? 1'b0 : s_hist[k];
  endfunction

  // A rise first sampled at edge k is accumulated at edge k+2; a window whose
  // accumulate edges are a..b therefore owns transitions ending at a-2..b-2.
  function automatic int rises(input int a, input int b);
    int n = 0;
    for (int j = a; j <= b; j++) begin
      if (sv(j - 2) && !sv(j - 3)) n++;
    end
    return n;
  endfunction

  task automatic step();
    @(negedge clk);
    if (release_pending) begin
      rst_n = 1'b1;
      release_pending = 1'b0;
      in_reset = 1'b0;
      cyc = 0;
      win_start = 3;
      win_end = -1;
      exp_main = 0;
      exp_sat = 0;
    end
    if (rand_mode) begin
      if ($urandom_range(0, 3) == 0) in_sig = ~in_sig;
    end else if (hold_half == 0) begin
      in_sig = hold_level;
    end else begin
      tog_cnt++;
      if (tog_cnt >= hold_half) begin
        tog_cnt = 0;
        in_sig = ~in_sig;
      end
    end
    if (!in_reset) begin
      if (cyc + 1 >= MAXC) begin
        $display("FAIL history_overflow: got %0d expected below %0d", cyc + 1, MAXC);
        $fatal(1);
      end
      s_hist[cyc + 1] = in_sig;
      f_hist[cyc + 1] = freq;
    end
    @(posedge clk);
    #1;
    if (in_reset) begin
      check("rst_count", count, 0);
      check("rst_valid", valid, 0);
      check("rst_count_sat", count_s, 0);
      check("rst_valid_sat", valid_s, 0);
    end else begin
      cyc++;
      if (cyc == win_start) win_end = win_start + (BASE << f_hist[cyc]) - 1;
      if (cyc == win_end) begin
        int n;
        n = rises(win_start, win_end);
        exp_main = (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
        exp_sat  = (n > (1 << SW) - 1) ? (1 << SW) - 1 : n;
      end
      check("model_valid", valid, (cyc == win_end) ? 1 : 0);
      check("model_count", count, exp_main);
      check("model_valid_sat", valid_s, (cyc == win_end) ? 1 : 0);
      check("model_count_sat", count_s, exp_sat);
      if (cyc == win_end) win_start = win_end + 1;
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, holds for some
  // cycles and arms release on the next falling edge.
  task automatic apply_reset(input int hold);
    #4;
    rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_valid", valid, 0);
    check("async_rst_count_sat", count_s, 0);
    repeat (hold) step();
    release_pending = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int budget, output int at);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    at = -1;
    while (n < budget && !got) begin
      step();
      n++;
      if (valid) begin
        got = 1'b1;
        at = cyc;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: got no valid expected one within %0d cycles", name, budget);
    end
  endtask

  initial begin
    int a;
    int b;
    int prev;

    vecs[0] = '{4,  1'b0, 4'd0, 8,  8};
    vecs[1] = '{2,  1'b0, 4'd0, 16, 15};
    vecs[2] = '{1,  1'b0, 4'd0, 32, 15};
    vecs[3] = '{8,  1'b0, 4'd1, 8,  8};
    vecs[4] = '{16, 1'b0, 4'd2, 8,  8};
    vecs[5] = '{32, 1'b0, 4'd3, 8,  8};
    vecs[6] = '{0,  1'b0, 4'd2, 0,  0};
    vecs[7] = '{0,  1'b1, 4'd0, 0,  0};
    vecs[8] = '{4,  1'b0, 4'd3, 64, 15};
    vecs[9] = '{2,  1'b0, 4'd1, 32, 15};

    // Power-up reset
    repeat (3) step();
    release_pending = 1'b1;

    // Vector table: skip two windows after each change, then check two
    // steady-state windows and the spacing between them.
    foreach (vecs[i]) begin
      hold_half  = vecs[i].half;
      hold_level = vecs[i].level;
      tog_cnt    = 0;
      freq       = vecs[i].f;
      wait_valid("tbl_settle1", 6 * 512 + 20, a);
      wait_valid("tbl_settle2", 6 * 512 + 20, a);
      wait_valid("tbl_win1", 6 * 512 + 20, a);
      check("tbl_count", count, vecs[i].exp);
      check("tbl_count_sat", count_s, vecs[i].exp_sat);
      wait_valid("tbl_win2", 6 * 512 + 20, b);
      check("tbl_count", count, vecs[i].exp);
      check("tbl_count_sat", count_s, vecs[i].exp_sat);
      if (a >= 0 && b >= 0) check("tbl_period", b - a, BASE << vecs[i].f);
    end

    // freq change halfway through a window: takes effect one window later.
    apply_reset(2);
    hold_half = 4;
    hold_level = 1'b0;
    tog_cnt = 0;
    freq = 4'd0;
    wait_valid("fchg_w0", 200, prev);
    wait_valid("fchg_w1", 200, prev);
    repeat (BASE / 2) step();
    freq = 4'd1;
    wait_valid("fchg_old", 400, a);
    check("fchg_old_count", count, 8);
    if (a >= 0 && prev >= 0) check("fchg_old_period", a - prev, BASE);
    wait_valid("fchg_new", 400, b);
    check("fchg_new_count", count, 16);
    if (a >= 0 && b >= 0) check("fchg_new_period", b - a, 2 * BASE);

    // Reset mid-window: window discarded, timing restarts after release.
    freq = 4'd0;
    wait_valid("mid_pre", 400, a);
    repeat (BASE / 2) step();
    apply_reset(3);
    wait_valid("mid_first", 400, a);
    check("mid_first_at", a, BASE + 2);
    check("mid_first_count", count, exp_main);
    wait_valid("mid_second", 400, b);
    check("mid_second_count", count, 8);

    // Randomised IN and freq with one random-length reset in the middle.
    apply_reset(2);
    rand_mode = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) freq = 4'($urandom_range(0, 3));
      if (i == 2000) apply_reset($urandom_range(1, 4));
      step();
    end
    rand_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
